// File: rtl/rotary_bank.sv
// rotary_bank: CHANNELS quadrature encoders -> 2-flop sync, debounce, 4x decode, bounded value regs; optional step acceleration under `ROTARY_ACCEL_EN`.
// Latency: pin edge to value/step_pulse is 2 + DEB_CYCLES + 1 cycles (19 with DEB_CYCLES=16).
// Backpressure: none; free-running, every decoded edge is applied in the cycle it is decoded.
module rotary_bank #(
  parameter int CHANNELS     = 4,
  parameter int BITS         = 12,
  parameter int INC          = 32,
  parameter int INIT         = 0,
  parameter int MIN          = 0,
  parameter int MAX          = 4095,
  parameter int WRAP         = 0,
  parameter int DEB_CYCLES   = 16,
  parameter int ACCEL_WINDOW = 4096,
  parameter int ACCEL_MULT   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [CHANNELS-1:0]      quad_a,
  input  logic [CHANNELS-1:0]      quad_b,
  input  logic [CHANNELS-1:0]      clr,
  output logic [CHANNELS*BITS-1:0] value,
  output logic [CHANNELS-1:0]      step_pulse,
  output logic [CHANNELS-1:0]      step_dir
);

  // Inputs are handled as one vector: bits [CHANNELS-1:0] are A pins, the upper half B pins.
  localparam int NIN = 2 * CHANNELS;
  // Counter only has to reach DEB_CYCLES-1.
  localparam int CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  // One extra bit so v+S and MIN+S never overflow.
  localparam int AW  = BITS + 1;

  localparam logic [CW-1:0]   DEB_LAST = CW'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);
  localparam logic [AW-1:0]   MIN_W    = AW'(MIN);
  localparam logic [AW-1:0]   MAX_W    = AW'(MAX);
  localparam logic [AW-1:0]   RANGE_W  = AW'(MAX - MIN + 1);
  localparam logic [AW-1:0]   INC_W    = AW'(INC);
  localparam logic [BITS-1:0] MIN_V    = BITS'(MIN);
  localparam logic [BITS-1:0] MAX_V    = BITS'(MAX);
  localparam logic [BITS-1:0] INIT_V   = BITS'(INIT);

  logic [NIN-1:0]                 sync1_q, sync1_d;
  logic [NIN-1:0]                 sync2_q, sync2_d;
  logic [NIN-1:0]                 deb_q, deb_d;
  logic [NIN-1:0]                 prev_q, prev_d;
  logic [NIN-1:0]                 deb_s;
  logic [NIN-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [CHANNELS-1:0][BITS-1:0]  val_q, val_d;
  logic [CHANNELS-1:0]            pulse_q, pulse_d;
  logic [CHANNELS-1:0]            dir_q, dir_d;
  logic [CHANNELS-1:0]            stp_edge, stp_up;
  logic [CHANNELS-1:0][AW-1:0]    stp_size, sum_up, lim_dn;
  logic [CHANNELS-1:0][BITS-1:0]  nxt_val;

  // Two-flop synchroniser on every raw encoder pin.
  always_comb begin
    sync1_d = {quad_b, quad_a};
    sync2_d = sync1_q;
  end

  // Debounce: the filtered state follows the sample only after DEB_CYCLES consecutive differing cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (DEB_CYCLES == 0) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // With the filter bypassed the decoder looks straight at the synchroniser output.
  always_comb begin
    deb_s  = (DEB_CYCLES == 0) ? sync2_q : deb_q;
    prev_d = deb_s;
  end

  // 4x quadrature decode; a double change cancels in the XOR and is dropped.
  always_comb begin
    stp_edge = '0;
    stp_up   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      stp_edge[c] = deb_s[c] ^ prev_q[c] ^ deb_s[CHANNELS+c] ^ prev_q[CHANNELS+c];
      stp_up[c]   = prev_q[c] ^ deb_s[CHANNELS+c];
    end
  end

`ifdef ROTARY_ACCEL_EN
  localparam int              TW      = $clog2(ACCEL_WINDOW + 1);
  localparam logic [TW-1:0]   TMR_SAT = TW'(ACCEL_WINDOW);
  localparam logic [AW-1:0]   FAST_W  = AW'(INC * ACCEL_MULT);

  logic [CHANNELS-1:0][TW-1:0] tmr_q, tmr_d;

  // Per-channel time-since-step; a recent step selects the multiplied step size.
  always_comb begin
    tmr_d    = tmr_q;
    stp_size = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      stp_size[c] = (tmr_q[c] < TMR_SAT) ? FAST_W : INC_W;
      if (clr[c]) begin
        tmr_d[c] = TMR_SAT;
      end else if (stp_edge[c]) begin
        tmr_d[c] = '0;
      end else if (tmr_q[c] < TMR_SAT) begin
        tmr_d[c] = tmr_q[c] + 1'b1;
      end
    end
  end

  // Timers start saturated so the first step after reset is never accelerated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr_q <= {CHANNELS{TMR_SAT}};
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  localparam int accel_unused = ACCEL_WINDOW + ACCEL_MULT;

  // Without acceleration every step moves by INC.
  assign stp_size = {CHANNELS{INC_W}};
`endif

  // Candidate next value for an edge: clamp at the bounds or wrap modulo the range.
  always_comb begin
    sum_up  = '0;
    lim_dn  = '0;
    nxt_val = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_up[c] = {1'b0, val_q[c]} + stp_size[c];
      lim_dn[c] = MIN_W + stp_size[c];
      if (stp_up[c]) begin
        if (sum_up[c] > MAX_W) begin
          nxt_val[c] = (WRAP != 0) ? BITS'(sum_up[c] - RANGE_W) : MAX_V;
        end else begin
          nxt_val[c] = BITS'(sum_up[c]);
        end
      end else begin
        if ({1'b0, val_q[c]} < lim_dn[c]) begin
          nxt_val[c] = (WRAP != 0) ? BITS'({1'b0, val_q[c]} + RANGE_W - stp_size[c]) : MIN_V;
        end else begin
          nxt_val[c] = BITS'({1'b0, val_q[c]} - stp_size[c]);
        end
      end
    end
  end

  // Register update; clear wins over a coincident edge and suppresses its strobe.
  always_comb begin
    val_d   = val_q;
    pulse_d = '0;
    dir_d   = dir_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (clr[c]) begin
        val_d[c] = INIT_V;
      end else if (stp_edge[c]) begin
        val_d[c]   = nxt_val[c];
        pulse_d[c] = 1'b1;
        dir_d[c]   = stp_up[c];
      end
    end
  end

  // All per-channel state; reset discards any partial debounce or rotation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      val_q   <= {CHANNELS{INIT_V}};
      pulse_q <= '0;
      dir_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
    end
  end

  assign value      = val_q;
  assign step_pulse = pulse_q;
  assign step_dir   = dir_q;

endmodule

// File: tb/tb_rotary_bank.sv
// tb_rotary_bank: random encoder stimulus on a clamping and a wrapping rotary_bank sharing the same pins.
// Expected steps/clears/resets are queued with their landing cycle; a monitor checks every lane every cycle.
// Up direction is the Gray order (A,B) 00->01->11->10->00, i.e. B leads A.
module tb_rotary_bank;
  localparam int CH = 4, BITS = 12, INC = 32, DEB = 16, LAT = DEB + 3, WIN = 4096, MULT = 4;
  localparam int C_INIT = 0,  C_MIN = 0,  C_MAX = 4095;
  localparam int W_INIT = 96, W_MIN = 16, W_MAX = 4015;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [CH-1:0] quad_a = '0, quad_b = '0, clr = '0;
  logic [CH*BITS-1:0] value_c, value_w;
  logic [CH-1:0] pulse_c, pulse_w, dir_c, dir_w;

  rotary_bank #(.CHANNELS(CH), .BITS(BITS), .INC(INC), .INIT(C_INIT), .MIN(C_MIN), .MAX(C_MAX),
                .WRAP(0), .DEB_CYCLES(DEB), .ACCEL_WINDOW(WIN), .ACCEL_MULT(MULT)) dut_c (
    .clk(clk), .resetn(resetn), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
    .value(value_c), .step_pulse(pulse_c), .step_dir(dir_c));

  rotary_bank #(.CHANNELS(CH), .BITS(BITS), .INC(INC), .INIT(W_INIT), .MIN(W_MIN), .MAX(W_MAX),
                .WRAP(1), .DEB_CYCLES(DEB), .ACCEL_WINDOW(WIN), .ACCEL_MULT(MULT)) dut_w (
    .clk(clk), .resetn(resetn), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
    .value(value_w), .step_pulse(pulse_w), .step_dir(dir_w));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = step, 1 = clear, 2 = reset
  typedef struct {int cyc; int kind; int val; int dir;} ev_t;
  ev_t evq [2*CH][$];

  int n_chk = 0, n_fail = 0;
  int cur_val [2*CH];
  int cur_dir [2*CH];
  int m_val [2*CH];
  int m_dir [2*CH];
  int pin_a [CH];
  int pin_b [CH];
  int last_step [CH];
  bit sat [CH];

  function automatic int init_of(int inst);
    return (inst == 0) ? C_INIT : W_INIT;
  endfunction

  function automatic int next_val(int inst, int v, int up, int s);
    int lo, hi, r;
    lo = (inst == 0) ? C_MIN : W_MIN;
    hi = (inst == 0) ? C_MAX : W_MAX;
    r  = hi - lo + 1;
    if (inst == 0) begin
      if (up != 0) return (v + s > hi) ? hi : v + s;
      return (v - s < lo) ? lo : v - s;
    end
    if (up != 0) return lo + (v - lo + s) % r;
    return lo + ((v - lo - s) % r + r) % r;
  endfunction

  function automatic int pos_of(int a, int b);
    if (a == 0 && b == 0) return 0;
    if (a == 0 && b != 0) return 1;
    if (a != 0 && b != 0) return 2;
    return 3;
  endfunction

  task automatic check(input string name, input int k, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s lane %0d cycle %0d: got %0d, expected %0d", name, k, cyc, got, want);
    end
  endtask

  // Monitor: apply events landing this cycle, then compare every lane.
  always @(negedge clk) begin
    for (int k = 0; k < 2*CH; k++) begin
      int ch, got_v, got_p, got_d, exp_p;
      ev_t e;
      ch = k % CH;
      exp_p = 0;
      while (evq[k].size() > 0 && evq[k][0].cyc <= cyc) begin
        e = evq[k].pop_front();
        if (e.cyc != cyc) check("event_cycle", k, cyc, e.cyc);
        cur_val[k] = e.val;
        if (e.kind == 0) begin
          exp_p = 1;
          cur_dir[k] = e.dir;
        end else if (e.kind == 2) begin
          cur_dir[k] = 0;
        end
      end
      got_v = (k < CH) ? int'(value_c[ch*BITS +: BITS]) : int'(value_w[ch*BITS +: BITS]);
      got_p = (k < CH) ? int'(pulse_c[ch]) : int'(pulse_w[ch]);
      got_d = (k < CH) ? int'(dir_c[ch]) : int'(dir_w[ch]);
      check("step_pulse", k, got_p, exp_p);
      check("value", k, got_v, cur_val[k]);
      check("step_dir", k, got_d, cur_dir[k]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic turn(input int ch, input int up);
    int np;
    np = (pos_of(pin_a[ch], pin_b[ch]) + ((up != 0) ? 1 : 3)) % 4;
    pin_a[ch] = (np >= 2) ? 1 : 0;
    pin_b[ch] = (np == 1 || np == 2) ? 1 : 0;
    quad_a[ch] = (pin_a[ch] != 0);
    quad_b[ch] = (pin_b[ch] != 0);
  endtask

  task automatic model_step(input int ch, input int up, input int land);
    int s, k;
    s = INC;
`ifdef ROTARY_ACCEL_EN
    if (!sat[ch] && (land - last_step[ch] - 1) < WIN) s = INC * MULT;
    sat[ch] = 1'b0;
    last_step[ch] = land;
`endif
    for (int inst = 0; inst < 2; inst++) begin
      k = inst * CH + ch;
      m_val[k] = next_val(inst, m_val[k], up, s);
      m_dir[k] = up;
      evq[k].push_back('{land, 0, m_val[k], up});
    end
  endtask

  task automatic model_clr(input int ch, input int land);
    int k;
    for (int inst = 0; inst < 2; inst++) begin
      k = inst * CH + ch;
      m_val[k] = init_of(inst);
      evq[k].push_back('{land, 1, m_val[k], m_dir[k]});
    end
    sat[ch] = 1'b1;
  endtask

  task automatic model_reset(input int land);
    for (int k = 0; k < 2*CH; k++) begin
      m_val[k] = init_of(k / CH);
      m_dir[k] = 0;
      evq[k].push_back('{land, 2, m_val[k], 0});
    end
    for (int c = 0; c < CH; c++) begin
      sat[c] = 1'b1;
      pin_a[c] = 0;
      pin_b[c] = 0;
    end
  endtask

  task automatic act_move(input int mask, input int up);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        turn(c, up);
        model_step(c, up, cyc + LAT);
      end
    end
  endtask

  task automatic act_glitch(input int ch, input int on_a, input int g);
    if (on_a != 0) quad_a[ch] = ~quad_a[ch]; else quad_b[ch] = ~quad_b[ch];
    tick(g);
    if (on_a != 0) quad_a[ch] = ~quad_a[ch]; else quad_b[ch] = ~quad_b[ch];
  endtask

  // Contact chatter on the pin about to change, then the real edge.
  task automatic act_bounce(input int ch, input int up);
    int np, on_a, n;
    np = (pos_of(pin_a[ch], pin_b[ch]) + ((up != 0) ? 1 : 3)) % 4;
    on_a = (((np >= 2) ? 1 : 0) != pin_a[ch]) ? 1 : 0;
    n = $urandom_range(1, 3);
    repeat (n) begin
      act_glitch(ch, on_a, $urandom_range(1, 10));
      tick($urandom_range(1, 5));
    end
    act_move(1 << ch, up);
  endtask

  task automatic act_clr(input int ch);
    clr[ch] = 1'b1;
    model_clr(ch, cyc + 1);
    tick(1);
    clr[ch] = 1'b0;
  endtask

  // Clear asserted exactly in the cycle the edge reaches the value register.
  task automatic act_clr_edge(input int ch, input int up);
    turn(ch, up);
    tick(LAT - 1);
    clr[ch] = 1'b1;
    model_clr(ch, cyc + 1);
    tick(1);
    clr[ch] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d, limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, ch, up, mask;
    for (int k = 0; k < 2*CH; k++) begin
      cur_val[k] = init_of(k / CH);
      cur_dir[k] = 0;
      m_val[k]   = init_of(k / CH);
      m_dir[k]   = 0;
    end
    for (int c = 0; c < CH; c++) begin
      pin_a[c] = 0;
      pin_b[c] = 0;
      sat[c] = 1'b1;
      last_step[c] = 0;
    end

    tick(5);
    resetn = 1'b1;
    tick(100);

    // One full detent on channel 0, edges 40 cycles apart.
    for (int i = 0; i < 4; i++) begin
      act_move(1, 1);
      tick(40);
    end

    // Short glitch never reaches the decoder.
    act_glitch(0, 1, 10);
    tick(40);

    // Drive all channels into the upper bound and back down to the lower one.
    repeat (140) begin
      act_move((1 << CH) - 1, 1);
      tick(21);
    end
    repeat (140) begin
      act_move((1 << CH) - 1, 0);
      tick(21);
    end

    repeat (300) begin
      r    = $urandom_range(0, 9);
      ch   = $urandom_range(0, CH - 1);
      up   = $urandom_range(0, 1);
      mask = $urandom_range(1, (1 << CH) - 1);
      case (r)
        5:       act_bounce(ch, up);
        6:       act_glitch(ch, $urandom_range(0, 1), $urandom_range(1, 12));
        7:       act_clr(ch);
        8:       act_clr_edge(ch, up);
        default: act_move(mask, up);
      endcase
      tick(20 + $urandom_range(0, 40));
    end

    // Reset in the middle of a debounce window: no step may survive it.
    turn(0, 1);
    turn(2, 0);
    tick(8);
    resetn = 1'b0;
    quad_a = '0;
    quad_b = '0;
    model_reset(cyc);
    tick(5);
    resetn = 1'b1;
    tick(100);

    // Step timing sequence: close steps, then a long idle.
    act_clr(0);
    tick(20);
    act_move(1, 1);
    tick(100);
    act_move(1, 1);
    tick(5000);
    act_move(1, 1);
    tick(40);

    for (int k = 0; k < 2*CH; k++) check("queue_drained", k, evq[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
